lock_key_loader: RTL and testbench
==================================

Name: lock_key_loader

Overview:
- Sequences activation of a key-locked combinational netlist: c432-style, 20 key inputs, each key pair selecting one of four candidate nets per mux.
- Receives key bits serially from the on-chip key store over a valid/ready stream and verifies a 4-bit XOR checksum.
- Presents the key to the locked netlist's D_* inputs only after verification. Until then, and after any failure or zeroize, the bus holds DEFAULT_KEY.
- Sits between the key-store reader and the locked core; one instance per locked core.

Parameters:
- KEY_BITS, 20, number of key inputs on the locked core.
- CHK_BITS, 4, checksum width; the key is zero-padded to a multiple of CHK_BITS, then XOR-folded.
- DEFAULT_KEY, 0, key_out value whenever no verified key is held.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin a key load.
- zeroize  in  1  level: erase key, return to IDLE.
- key_in_bit  in  1  serial key/checksum bit, LSB first.
- key_in_valid  in  1  key_in_bit is valid.
- key_in_ready  out  1  loader accepts a bit this cycle.
- key_out  out  KEY_BITS  key bus to locked core D_0..D_(KEY_BITS-1).
- key_valid  out  1  key_out holds a verified key.
- load_busy  out  1  high in LOAD or CHECK.
- load_err  out  1  sticky checksum failure.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n. All state updates on the rising edge.
- Reset values: state=IDLE, key_out=DEFAULT_KEY, key_valid=0, load_busy=0, load_err=0, key_in_ready=0, shift register=0, bit counter=0.
- States: IDLE, LOAD, CHECK, ARMED, FAIL.
- IDLE:
  - start -> LOAD; counter cleared; load_err cleared.
- LOAD:
  - key_in_ready=1.
  - A bit is accepted when key_in_valid && key_in_ready.
  - Bit n goes to shadow[n] for n<KEY_BITS, else to chk[n-KEY_BITS].
  - Counter width is $clog2(KEY_BITS+CHK_BITS+1).
  - On acceptance of bit KEY_BITS+CHK_BITS-1 -> CHECK.
  - Gaps in valid stall the load indefinitely; there is no timeout.
- CHECK (exactly 1 cycle):
  - key_in_ready=0.
  - Compare the XOR of the CHK_BITS-wide slices of the shadow register with chk.
  - Match -> ARMED and key_out<=shadow. Mismatch -> FAIL and load_err<=1.
- ARMED:
  - key_valid=1; key_out stable.
- FAIL:
  - key_out=DEFAULT_KEY; key_valid=0; load_err=1.
- key_out never shows a partial or unverified key; it changes only on the CHECK->ARMED transition or on a return to DEFAULT_KEY.
- Latency: key_valid rises in the second cycle after the cycle of the final bit handshake.
- start in ARMED or FAIL:
  - Next cycle LOAD, key_valid=0, key_out=DEFAULT_KEY, load_err=0.
- start in LOAD or CHECK is ignored.
- zeroize has the highest priority, above start and handshake:
  - Next state IDLE; shadow, chk and counter cleared; key_out=DEFAULT_KEY; key_valid=0; load_err=0.
  - While zeroize is held: start is ignored and key_in_ready=0.
- Reset mid-load behaves as zeroize. No bit is accepted in the reset cycle.
- load_busy = (state==LOAD || state==CHECK).

Decomposition:
- Package lock_key_pkg holds:
  - state enum lock_key_state_e.
  - localparams for the padded key width and slice count.
  - function chk_fold(key) returning the CHK_BITS XOR fold.
- One natural sub-module: lock_key_shifter, containing the shadow register, checksum register, bit counter and the done flag.
- FSM and output registers stay in lock_key_loader.

Test Plan:
- Load with continuous valid:
  - Stimulus: start at cycle 0, then key 20'hA5C3F LSB-first followed by chk 4'hF.
  - Required: ready high in cycles 1-24; CHECK in cycle 25; cycle 26 key_out=20'hA5C3F, key_valid=1, load_err=0.
- Bad checksum:
  - Stimulus: same key with chk 4'hE.
  - Required: FAIL; load_err=1; key_valid=0; key_out=0 throughout.
- Stalled stream:
  - Stimulus: key_in_valid toggled 1/0 every cycle.
  - Required: exactly 24 handshakes; key_valid rises 2 cycles after the 24th handshake; the value matches the loaded key.
- Zeroize:
  - Stimulus: zeroize after bit 10 of a load. Then zeroize while ARMED with 20'hA5C3F.
  - Required: next cycle IDLE, key_out=0, key_valid=0. A subsequent fresh load succeeds.
- Restart from ARMED:
  - Stimulus: start while ARMED, then load 20'h0000F with chk 4'hF.
  - Required: key_valid drops and key_out=0 the next cycle; final key_out=20'h0000F.
- Ignored start and reset:
  - Stimulus: start pulsed mid-LOAD. Separately, rst_n low mid-load for 1 cycle.
  - Required: the pulsed start has no effect and the load completes normally. The rst_n case returns to all reset values, with no bit accepted in that cycle.

Source files
------------

// File: rtl/lock_key_pkg.sv
// Shared types, sizing constants and the checksum fold for the key loader.
// The key is zero-padded to whole checksum slices before XOR folding.
package lock_key_pkg;

    localparam int KEY_BITS   = 20;
    localparam int CHK_BITS   = 4;
    localparam int TOTAL_BITS = KEY_BITS + CHK_BITS;
    localparam int PAD_BITS   = ((KEY_BITS + CHK_BITS - 1) / CHK_BITS) * CHK_BITS;
    localparam int SLICES     = PAD_BITS / CHK_BITS;
    localparam int CNT_W      = $clog2(KEY_BITS + CHK_BITS + 1);

    localparam logic [KEY_BITS-1:0] DEFAULT_KEY = {KEY_BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARMED = 3'd3,
        ST_FAIL  = 3'd4
    } lock_key_state_e;

    function automatic logic [CHK_BITS-1:0] chk_fold(input logic [KEY_BITS-1:0] key);
        logic [PAD_BITS-1:0] padded;
        logic [CHK_BITS-1:0] acc;
        padded                 = {PAD_BITS{1'b0}};
        padded[KEY_BITS-1:0]   = key;
        acc                    = {CHK_BITS{1'b0}};
        for (int i = 0; i < SLICES; i++) begin
            acc = acc ^ padded[i*CHK_BITS +: CHK_BITS];
        end
        return acc;
    endfunction

endpackage

// File: rtl/lock_key_shifter.sv
// Serial capture of the key shadow and its checksum, LSB first.
// done marks the handshake that carries the last checksum bit.
module lock_key_shifter
    import lock_key_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                bit_in,
    output logic [KEY_BITS-1:0] shadow,
    output logic [CHK_BITS-1:0] chk,
    output logic                done
);

    logic [CNT_W-1:0]    cnt_r;
    logic [KEY_BITS-1:0] shadow_r;
    logic [CHK_BITS-1:0] chk_r;
    logic                key_phase_s;

    assign key_phase_s = (cnt_r < CNT_W'(KEY_BITS));
    assign done        = shift_en && (cnt_r == CNT_W'(TOTAL_BITS - 1));
    assign shadow      = shadow_r;
    assign chk         = chk_r;

    // Shift registers fill from the top so bit 0 lands at index 0 once full.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_r    <= {CNT_W{1'b0}};
            shadow_r <= {KEY_BITS{1'b0}};
            chk_r    <= {CHK_BITS{1'b0}};
        end else if (shift_en) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (key_phase_s) begin
                shadow_r <= {bit_in, shadow_r[KEY_BITS-1:1]};
            end else begin
                chk_r <= {bit_in, chk_r[CHK_BITS-1:1]};
            end
        end
    end

endmodule

// File: rtl/lock_key_loader.sv
// Loads a serial key, verifies its XOR checksum, and only then drives the
// locked core's key bus; otherwise the bus holds DEFAULT_KEY.
module lock_key_loader
    import lock_key_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                zeroize,
    input  logic                key_in_bit,
    input  logic                key_in_valid,
    output logic                key_in_ready,
    output logic [KEY_BITS-1:0] key_out,
    output logic                key_valid,
    output logic                load_busy,
    output logic                load_err
);

    lock_key_state_e     state_r, state_nxt_s;
    logic [KEY_BITS-1:0] shadow_s, key_out_r, key_out_nxt_s;
    logic [CHK_BITS-1:0] chk_s;
    logic                done_s, chk_ok_s, handshake_s, clear_s, restart_s;
    logic                ready_r, ready_nxt_s;
    logic                key_valid_r, key_valid_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                err_r, err_nxt_s;

    // Ready is dropped at once by zeroize or reset so no bit slips in that cycle.
    assign key_in_ready = ready_r && rst_n && !zeroize;
    assign handshake_s  = key_in_valid && key_in_ready;
    assign restart_s    = start && ((state_r == ST_IDLE) || (state_r == ST_ARMED) ||
                                    (state_r == ST_FAIL));
    assign clear_s      = zeroize || restart_s;
    assign chk_ok_s     = (chk_fold(shadow_s) == chk_s);

    assign key_out   = key_out_r;
    assign key_valid = key_valid_r;
    assign load_busy = busy_r;
    assign load_err  = err_r;

    lock_key_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .shift_en (handshake_s),
        .bit_in   (key_in_bit),
        .shadow   (shadow_s),
        .chk      (chk_s),
        .done     (done_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; zeroize overrides every other input.
    always_comb begin
        state_nxt_s = state_r;
        if (zeroize) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = start ? ST_LOAD : ST_IDLE;
                ST_LOAD:  state_nxt_s = done_s ? ST_CHECK : ST_LOAD;
                ST_CHECK: state_nxt_s = chk_ok_s ? ST_ARMED : ST_FAIL;
                ST_ARMED: state_nxt_s = start ? ST_LOAD : ST_ARMED;
                ST_FAIL:  state_nxt_s = start ? ST_LOAD : ST_FAIL;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output values for the next cycle follow from where the FSM is heading.
    always_comb begin
        ready_nxt_s     = (state_nxt_s == ST_LOAD);
        busy_nxt_s      = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_CHECK);
        key_valid_nxt_s = (state_nxt_s == ST_ARMED);
        err_nxt_s       = (state_nxt_s == ST_FAIL);
        key_out_nxt_s   = DEFAULT_KEY;
        if (state_nxt_s == ST_ARMED) begin
            if (state_r == ST_CHECK) begin
                key_out_nxt_s = shadow_s;
            end else begin
                key_out_nxt_s = key_out_r;
            end
        end else begin
            key_out_nxt_s = DEFAULT_KEY;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            key_valid_r <= 1'b0;
            err_r       <= 1'b0;
            key_out_r   <= DEFAULT_KEY;
        end else begin
            ready_r     <= ready_nxt_s;
            busy_r      <= busy_nxt_s;
            key_valid_r <= key_valid_nxt_s;
            err_r       <= err_nxt_s;
            key_out_r   <= key_out_nxt_s;
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader: table-driven loads, hand-written
// zeroize/reset sequences and random loads against a behavioural model.
module tb_lock_key_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, zeroize, key_in_bit, key_in_valid;
    logic        key_in_ready, key_valid, load_busy, load_err;
    logic [19:0] key_out;

    lock_key_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .zeroize      (zeroize),
        .key_in_bit   (key_in_bit),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .load_busy    (load_busy),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: collects the bit stream, judges it one cycle later.
    bit          m_loading, m_pending, m_armed, m_failed;
    int          m_n;
    logic [19:0] m_key, m_out;
    logic [3:0]  m_chk;

    logic        s_ready, s_kv, s_err, s_busy;
    logic [19:0] s_key;

    typedef struct {
        logic [19:0] key;
        logic [3:0]  chk;
        int          mode;
        logic        exp_kv;
        logic [19:0] exp_out;
        logic        exp_err;
    } lk_vec_t;

    lk_vec_t vecs[8];

    function automatic int fold(input int k);
        int x, f;
        x = k;
        f = 0;
        for (int i = 0; i < 5; i++) begin
            f = f ^ (x % 16);
            x = x / 16;
        end
        return f;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_loading = 0; m_pending = 0; m_armed = 0; m_failed = 0;
        m_n = 0; m_key = 20'h0; m_chk = 4'h0; m_out = 20'h0;
    endtask

    task automatic tick(input logic st, input logic zz, input logic vv, input logic bb,
                        input logic rr);
        logic e_ready;
        start = st; zeroize = zz; key_in_valid = vv; key_in_bit = bb; rst_n = rr;
        #2;
        e_ready = m_loading && rr && !zz;
        s_ready = key_in_ready; s_kv = key_valid; s_err = load_err;
        s_busy = load_busy; s_key = key_out;
        check("ready", 32'(s_ready), 32'(e_ready));
        check("busy", 32'(s_busy), 32'(m_loading || m_pending));
        check("key_valid", 32'(s_kv), 32'(m_armed));
        check("load_err", 32'(s_err), 32'(m_failed));
        check("key_out", 32'(s_key), 32'(m_armed ? m_out : 20'h0));
        @(posedge clk);
        if (!rr || zz) begin
            model_clear();
        end else if (m_pending) begin
            m_pending = 0;
            if (fold(int'(m_key)) == int'(m_chk)) begin
                m_armed = 1;
                m_out   = m_key;
            end else begin
                m_failed = 1;
            end
        end else if (m_loading) begin
            if (vv) begin
                if (m_n < 20) m_key[m_n] = bb;
                else          m_chk[m_n-20] = bb;
                m_n++;
                if (m_n == 24) begin
                    m_loading = 0;
                    m_pending = 1;
                end
            end
        end else if (st) begin
            model_clear();
            m_loading = 1;
        end
        #1;
    endtask

    // mode 0: continuous valid, 1: valid toggles, 2: random valid, 3: continuous + stray start
    task automatic do_load(input logic [19:0] k, input logic [3:0] c, input int mode,
                           output int hs, output int lat);
        logic [23:0] stream;
        int          n, last_hs;
        bit          done;
        logic        vv, st;
        stream = {c, k};
        n = 0; last_hs = 0; done = 0; lat = -1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int cyc = 1; cyc < 300 && !done; cyc++) begin
            case (mode)
                1:       vv = (cyc % 2) == 1;
                2:       vv = 1'($urandom_range(0, 1));
                default: vv = 1'b1;
            endcase
            if (n >= 24) vv = 1'b0;
            st = (mode == 3) && (cyc == 8);
            tick(st, 1'b0, vv, (n < 24) ? stream[n] : 1'b0, 1'b1);
            if (cyc == 1) begin
                check("start_kv_drop", 32'(s_kv), 32'h0);
                check("start_key_clr", 32'(s_key), 32'h0);
            end
            if (vv && s_ready) begin
                n++;
                last_hs = cyc;
            end
            if (s_kv || s_err) begin
                done = 1;
                lat  = cyc - last_hs;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: got no verdict expected key_valid or load_err");
        end
        hs = n;
    endtask

    initial begin
        int          hs, lat;
        logic [19:0] rk;
        logic [3:0]  rc;

        vecs[0] = '{20'hA5C3F, 4'hF, 0, 1'b1, 20'hA5C3F, 1'b0};
        vecs[1] = '{20'hA5C3F, 4'hE, 0, 1'b0, 20'h00000, 1'b1};
        vecs[2] = '{20'hA5C3F, 4'hF, 1, 1'b1, 20'hA5C3F, 1'b0};
        vecs[3] = '{20'h0000F, 4'hF, 0, 1'b1, 20'h0000F, 1'b0};
        vecs[4] = '{20'h00000, 4'h0, 0, 1'b1, 20'h00000, 1'b0};
        vecs[5] = '{20'hFFFFF, 4'hF, 3, 1'b1, 20'hFFFFF, 1'b0};
        vecs[6] = '{20'h12345, 4'h1, 0, 1'b1, 20'h12345, 1'b0};
        vecs[7] = '{20'h12345, 4'h0, 1, 1'b0, 20'h00000, 1'b1};

        rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; key_in_bit = 1'b0; key_in_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_key_out", 32'(s_key), 32'h0);
        check("rst_ready", 32'(s_ready), 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].key, vecs[i].chk, vecs[i].mode, hs, lat);
            check("vec_handshakes", 32'(hs), 32'd24);
            check("vec_latency", 32'(lat), 32'd2);
            check("vec_key_valid", 32'(s_kv), 32'(vecs[i].exp_kv));
            check("vec_key_out", 32'(s_key), 32'(vecs[i].exp_out));
            check("vec_load_err", 32'(s_err), 32'(vecs[i].exp_err));
        end

        // Zeroize after ten bits, then a fresh load.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'(i % 2), 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("zz_ready_held", 32'(s_ready), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("zz_busy", 32'(s_busy), 32'h0);
        check("zz_key_valid", 32'(s_kv), 32'h0);
        check("zz_key_out", 32'(s_key), 32'h0);
        do_load(20'hA5C3F, 4'hF, 0, hs, lat);
        check("zz_reload_out", 32'(s_key), 32'hA5C3F);

        // Zeroize while armed.
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("zz_armed_kv", 32'(s_kv), 32'h0);
        check("zz_armed_out", 32'(s_key), 32'h0);
        check("zz_armed_busy", 32'(s_busy), 32'h0);

        // Reset for one cycle mid-load, then a fresh load.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_mid_ready", 32'(s_ready), 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_mid_busy", 32'(s_busy), 32'h0);
        check("rst_mid_ready2", 32'(s_ready), 32'h0);
        check("rst_mid_kv", 32'(s_kv), 32'h0);
        check("rst_mid_err", 32'(s_err), 32'h0);
        check("rst_mid_out", 32'(s_key), 32'h0);
        do_load(20'h0000F, 4'hF, 0, hs, lat);
        check("rst_reload_out", 32'(s_key), 32'h0000F);

        // Random loads with random valid gaps.
        for (int r = 0; r < 8; r++) begin
            rk = 20'($urandom);
            rc = (r % 2 == 0) ? 4'(fold(int'(rk))) : 4'($urandom);
            do_load(rk, rc, 2, hs, lat);
            check("rnd_handshakes", 32'(hs), 32'd24);
            check("rnd_kv", 32'(s_kv), 32'(fold(int'(rk)) == int'(rc)));
            check("rnd_out", 32'(s_key), (fold(int'(rk)) == int'(rc)) ? 32'(rk) : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
